// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type and width helpers for the APB memory slave
package apb_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} apb_state_t;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// apb_mem_slave_if: APB3/APB4 bus bundle between requester and completer
interface apb_mem_slave_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                  psel_i;
    logic                  penable_i;
    logic [ADDR_W-1:0]     paddr_i;
    logic                  pwrite_i;
    logic [DATA_W-1:0]     pwdata_i;
    logic [DATA_W/8-1:0]   pstrb_i;
    logic [DATA_W-1:0]     prdata_o;
    logic                  pready_o;
    logic                  pslverr_o;

    modport master (
        output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, pstrb_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, pstrb_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_wait_ctr.sv
// apb_wait_ctr: counts access-phase wait cycles; done on the last wait slot
module apb_wait_ctr #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    logic [CW-1:0] cnt;

    // count access cycles spent in ST_ACCESS, restart whenever the transfer ends
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end

    assign done = (WAIT_CYCLES != 0) && (cnt == LAST);
endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB completer backed by a strobe-writable register-file memory
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    apb_mem_slave_if.slave bus
);
    localparam int SW  = strb_w(DATA_W);
    localparam int OFF = $clog2(SW);
    localparam int IW  = ADDR_W - OFF;
    localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_state_t        state;
    logic              setup, access, done, ready, err, wr_ok, rd_ok;
    logic [IW-1:0]     idx;
    logic [MW-1:0]     widx;
    logic [DATA_W-1:0] mem [DEPTH];

    assign setup  = bus.psel_i & ~bus.penable_i;
    assign access = bus.psel_i & bus.penable_i;
    assign idx    = bus.paddr_i[ADDR_W-1:OFF];
    assign widx   = idx[MW-1:0];
    // an access with no preceding setup completes at once as an error
    assign ready  = reset_n & access & ((state == ST_IDLE)
                  | ((state == ST_SETUP) & (WAIT_CYCLES == 0))
                  | ((state == ST_ACCESS) & done));
    assign err    = (state == ST_IDLE) | (32'(idx) >= 32'(DEPTH))
                  | (|(bus.paddr_i & ADDR_W'(SW - 1)));
    assign wr_ok  = ready & bus.pwrite_i & ~err;
    assign rd_ok  = ready & ~bus.pwrite_i & ~err;

    assign bus.pready_o  = ready;
    assign bus.pslverr_o = ready & err;
    assign bus.prdata_o  = rd_ok ? mem[widx] : '0;

    apb_wait_ctr #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    ((state != ST_ACCESS) | ready | ~bus.psel_i),
        .en     ((state == ST_ACCESS) & access),
        .done   (done)
    );

    // transfer phase tracking; dropping psel aborts whatever is in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else if (ready) state <= setup ? ST_SETUP : ST_IDLE;
        else if (!bus.psel_i) state <= ST_IDLE;
        else state <= (state == ST_IDLE) ? (setup ? ST_SETUP : ST_IDLE)
                    : ((state == ST_SETUP) & access) ? ST_ACCESS : state;
    end

    // memory clears on reset; writes commit lane by lane on the completing edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < SW; b++)
                if (bus.pstrb_i[b]) mem[widx][b*8 +: 8] <= bus.pwdata_i[b*8 +: 8];
        end
    end
endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: scoreboard bench over WAIT_CYCLES = 1, 0 and 3 builds
module tb_apb_mem_slave;
    import apb_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [9:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    int          sel = 0;

    apb_mem_slave_if #(.ADDR_W(10), .DATA_W(32)) bus0 ();
    apb_mem_slave_if #(.ADDR_W(10), .DATA_W(32)) bus1 ();
    apb_mem_slave_if #(.ADDR_W(10), .DATA_W(32)) bus2 ();

    apb_mem_slave #(.WAIT_CYCLES(1)) u0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
    apb_mem_slave #(.WAIT_CYCLES(0)) u1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));
    apb_mem_slave #(.WAIT_CYCLES(3)) u2 (.clk(clk), .reset_n(reset_n), .bus(bus2.slave));

    assign bus0.psel_i = psel && sel == 0;
    assign bus1.psel_i = psel && sel == 1;
    assign bus2.psel_i = psel && sel == 2;
    assign {bus0.penable_i, bus1.penable_i, bus2.penable_i} = {3{penable}};
    assign {bus0.pwrite_i, bus1.pwrite_i, bus2.pwrite_i}    = {3{pwrite}};
    assign {bus0.paddr_i, bus1.paddr_i, bus2.paddr_i}       = {3{paddr}};
    assign {bus0.pwdata_i, bus1.pwdata_i, bus2.pwdata_i}    = {3{pwdata}};
    assign {bus0.pstrb_i, bus1.pstrb_i, bus2.pstrb_i}       = {3{pstrb}};

    logic [31:0] rd;
    logic        rdy, err;
    assign rd  = sel == 0 ? bus0.prdata_o  : sel == 1 ? bus1.prdata_o  : bus2.prdata_o;
    assign rdy = sel == 0 ? bus0.pready_o  : sel == 1 ? bus1.pready_o  : bus2.pready_o;
    assign err = sel == 0 ? bus0.pslverr_o : sel == 1 ? bus1.pslverr_o : bus2.pslverr_o;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl [3][128];
    int          waits [3] = '{1, 0, 3};
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut=%h ref=%h sel=%0d t=%0t", tag, act, expv, sel, $time);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 128; i++) mdl[k][i] = '0;
    endtask

    // push the reference outcome, run one setup+access transfer, pop and compare on pready
    task automatic xfer(input logic wr, input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        logic [7:0] idx;
        int n;
        idx   = a[9:2];
        e.err = (idx >= 8'd128) || (a[1:0] != 2'b00);
        if (wr && !e.err)
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[sel][idx[6:0]][b*8 +: 8] = d[b*8 +: 8];
        e.data = (!wr && !e.err) ? mdl[sel][idx[6:0]] : 32'h0;
        e.cyc  = waits[sel] + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (rdy) break;
            @(posedge clk); #1;
        end
        e = exp_q.pop_front();
        if (rdy) begin
            chk("rdata", rd, e.data);
            chk("slverr", {31'b0, err}, {31'b0, e.err});
            chk("cycles", n, e.cyc);
        end else begin
            chk("pready_timeout", 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog dut=hung ref=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        // reset held with an access pending: every output must stay low
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 10'h010;
        #12;
        chk("rst_pready", {31'b0, rdy}, 32'd0);
        chk("rst_pslverr", {31'b0, err}, 32'd0);
        chk("rst_prdata", rd, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // basic write/read and strobe merge
        sel = 0;
        xfer(1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
        xfer(1'b0, 10'h010, 32'h0, 4'h0);
        xfer(1'b1, 10'h020, 32'h11223344, 4'hF);
        xfer(1'b1, 10'h020, 32'hAABBCCDD, 4'b0101);
        xfer(1'b0, 10'h020, 32'h0, 4'h0);
        chk("merge_model", mdl[0][8], 32'h11BB33DD);
        xfer(1'b1, 10'h020, 32'hFFFFFFFF, 4'h0);
        xfer(1'b0, 10'h020, 32'h0, 4'h0);

        // out-of-range and misaligned accesses error out and leave memory alone
        xfer(1'b1, 10'h200, 32'h00000005, 4'hF);
        xfer(1'b0, 10'h003, 32'h0, 4'h0);
        xfer(1'b1, 10'h012, 32'h12345678, 4'hF);
        xfer(1'b0, 10'h200, 32'h0, 4'h0);
        xfer(1'b0, 10'h3FC, 32'h0, 4'h0);
        for (int i = 0; i < 128; i++) xfer(1'b0, 10'(i * 4), 32'h0, 4'h0);

        // access with no setup phase: immediate error, nothing written
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 10'h010; pwdata = 32'h0BADF00D; pstrb = 4'hF;
        @(negedge clk);
        chk("illegal_pready", {31'b0, rdy}, 32'd1);
        chk("illegal_pslverr", {31'b0, err}, 32'd1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        xfer(1'b0, 10'h010, 32'h0, 4'h0);

        // random traffic on all three wait-state builds
        for (int k = 0; k < 3; k++) begin
            sel = k;
            for (int i = 0; i < 10; i++) begin
                logic [9:0]  a;
                logic [31:0] d;
                logic [3:0]  s;
                a = 10'($urandom_range(0, 127) * 4);
                d = $urandom;
                s = 4'($urandom_range(1, 15));
                xfer(1'b1, a, d, s);
                xfer(1'b0, a, 32'h0, 4'h0);
            end
        end

        // psel dropped while a write waits: nothing committed
        sel = 2;
        xfer(1'b1, 10'h040, 32'h01020304, 4'hF);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h040; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abort_pready", {31'b0, rdy}, 32'd0);
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        xfer(1'b0, 10'h040, 32'h0, 4'h0);

        // reset pulse in the middle of a read
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 10'h040;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #2;
        chk("rstmid_pready", {31'b0, rdy}, 32'd0);
        chk("rstmid_prdata", rd, 32'd0);
        chk("rstmid_state", {30'b0, u2.state}, {30'b0, ST_IDLE});
        psel = 1'b0; penable = 1'b0;
        clear_model();
        @(posedge clk); #1;
        reset_n = 1'b1;
        xfer(1'b0, 10'h040, 32'h0, 4'h0);
        xfer(1'b0, 10'h000, 32'h0, 4'h0);
        sel = 0;
        xfer(1'b0, 10'h010, 32'h0, 4'h0);
        xfer(1'b0, 10'h020, 32'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
